wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 8 and set the writeback data width.
REQ-002 Parameter ADDR_WIDTH SHALL default to 3 and set the register-file address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 vld0  input  1  source 0 (ALU result) request valid.
REQ-006 addr0  input  ADDR_WIDTH  source 0 destination register.
REQ-007 data0  input  DATA_WIDTH  source 0 result.
REQ-008 rdy0  output  1  source 0 accepted this cycle; combinational.
REQ-009 vld1, addr1, data1, rdy1  SHALL mirror REQ-005..008 for source 1 (load result).
REQ-010 wr_stall  input  1  downstream register-file port busy; hold output stage.
REQ-011 wr_en  output  1  registered register-file write enable.
REQ-012 wr_addr  output  ADDR_WIDTH  registered write address.
REQ-013 wr_data  output  DATA_WIDTH  registered write data.
REQ-014 wr_sel  output  1  registered select for the 2:1 writeback mux; 0 = source 0, 1 = source 1.

Function
REQ-015 A transfer on source n SHALL occur when vldn and rdyn are both 1 in the same cycle.
REQ-016 rdy0 and rdy1 SHALL both be 0 whenever wr_stall=1 or rst=1.
REQ-017 With wr_stall=0 and exactly one vld high, that source's rdy SHALL be 1 and the other's 0.
REQ-018 With wr_stall=0 and both vld high, rdy SHALL be granted to the source not recorded in last_grant; exactly one rdy high.
REQ-019 No rdy SHALL be 1 when its own vld is 0.
REQ-020 last_grant (internal, 1 bit) SHALL update to the granted source index on every transfer and hold otherwise.
REQ-021 On a transfer, the next edge SHALL load wr_en=1, wr_addr/wr_data from the granted source, wr_sel=granted index; latency one cycle.
REQ-022 With wr_stall=0 and no transfer, the next edge SHALL load wr_en=0; wr_addr, wr_data, wr_sel hold.
REQ-023 With wr_stall=1, wr_en, wr_addr, wr_data, wr_sel and last_grant SHALL all hold their values.
REQ-024 Identical addr0 and addr1 under conflict SHALL receive no special treatment; arbitration per REQ-018, writes serialised over consecutive cycles.
REQ-025 Sustained dual requests with wr_stall=0 SHALL alternate grants every cycle; no source waits more than one cycle.
REQ-026 Throughput SHALL be one write per cycle while wr_stall=0 and any vld is high.

Reset
REQ-027 rst=1 at a clock edge SHALL set wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, last_grant=1, overriding any transfer or stall.
REQ-028 After rst deasserts, the first conflict SHALL be granted to source 0.
REQ-029 rst asserted mid-stream SHALL discard any pending or held write; no wr_en pulse SHALL appear for requests presented during reset.

Verification
REQ-030 Reset, then vld0=1 addr0=3 data0=0xA5 one cycle -> rdy0=1 same cycle; next cycle wr_en=1 wr_addr=3 wr_data=0xA5 wr_sel=0; following cycle wr_en=0.
REQ-031 Reset, then vld0=vld1=1 for 4 cycles (data0=0x11, data1=0x22) -> grants 0,1,0,1; wr_data sequence 0x11,0x22,0x11,0x22 with wr_sel 0,1,0,1.
REQ-032 Write pending (wr_en=1, wr_data=0x22), wr_stall=1 for 3 cycles with vld1=1 -> rdy1=0 throughout; wr_en/wr_data/wr_sel frozen; on release rdy1=1 next cycle.
REQ-033 vld1=1 only, addr1=7 data1=0xFF -> rdy1=1, rdy0=0; next cycle wr_sel=1 wr_addr=7 wr_data=0xFF; last_grant=1, so subsequent conflict grants source 0.
REQ-034 Both vld high with addr0=addr1=2, data0=0x01, data1=0x02 -> two consecutive writes to address 2, 0x01 then 0x02 after reset.
REQ-035 rst asserted in cycle where wr_en=1 and vld0=1 -> next cycle all outputs 0, rdy0=0 during reset; after release, vld0 transfer proceeds normally.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter: ALU (source 0) and load (source 1) results
// compete for one register-file write port, with round-robin fairness.
module wb_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  rdy0,
    input  logic                  vld1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  rdy1,
    input  logic                  wr_stall,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_sel
);

    logic                  last_grant;
    logic                  grant_sel_p0;
    logic                  xfer_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] data_p0;

    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  sel_p1;

    // Stage p0: grant decision and writeback mux, all combinational.
    always_comb begin
        rdy0         = 1'b0;
        rdy1         = 1'b0;
        grant_sel_p0 = 1'b0;
        if (!rst && !wr_stall) begin
            if (vld0 && vld1) begin
                // Conflict: the source that did not win last time goes first.
                grant_sel_p0 = ~last_grant;
                rdy0         = last_grant;
                rdy1         = ~last_grant;
            end else begin
                grant_sel_p0 = vld1;
                rdy0         = vld0;
                rdy1         = vld1;
            end
        end
    end

    assign xfer_p0 = (vld0 && rdy0) || (vld1 && rdy1);
    assign addr_p0 = grant_sel_p0 ? addr1 : addr0;
    assign data_p0 = grant_sel_p0 ? data1 : data0;

    // Stage p1: registered write port, frozen while the register file is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            addr_p1    <= '0;
            data_p1    <= '0;
            sel_p1     <= 1'b0;
            last_grant <= 1'b1;
        end else if (!wr_stall) begin
            vld_p1 <= xfer_p0;
            if (xfer_p0) begin
                addr_p1    <= addr_p0;
                data_p1    <= data_p0;
                sel_p1     <= grant_sel_p0;
                last_grant <= grant_sel_p0;
            end
        end
    end

    assign wr_en   = vld_p1;
    assign wr_addr = addr_p1;
    assign wr_data = data_p1;
    assign wr_sel  = sel_p1;

endmodule
